neuron_mac_sequencer: RTL
=========================

NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

Interface
REQ-001 SHALL have parameters, one per line: Width, 4, fixed-point word width.
REQ-002 SHALL have parameter Magnitud, 2, integer bits.
REQ-003 SHALL have parameter Precision, 1, fraction bits.
REQ-004 SHALL have parameter Signo, 1, sign bits.
REQ-005 SHALL have parameter NumInputs, 20, coefficients per neuron (1..20); the offset uses select NumInputs.
REQ-006 SHALL have ports, one per line: CLK  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 Start  in  1  begin one neuron evaluation (sampled in IDLE only).
REQ-009 InValid  in  1 / InReady  out  1  input-sample handshake.
REQ-010 InSample  in  Width  signed input sample.
REQ-011 SELCoeff  out  5 / EnableLoadCoeff, EnableMul, EnableSum  out  1 each  datapath controls.
REQ-012 InDato, Acumulador  out  Width  signed datapath operands.
REQ-013 OutDato  in  Width  signed datapath sum / Error  in  1  datapath overflow.
REQ-014 Result  out  Width / ResultValid  out  1 / ResultReady  in  1  result handshake.
REQ-015 Busy  out  1 (state != IDLE) / ErrorFlag  out  1  sticky overflow for current evaluation.

Function
REQ-016 SHALL implement states IDLE, LOAD, MAC, LOADOFF, MACOFF, DONE plus index counter idx (5 bits) and accumulator register acc (Width).
REQ-017 IDLE: Start=1 -> LOAD, idx<=0, acc<=0, ErrorFlag<=0; Start in any other state SHALL be ignored.
REQ-018 LOAD: EnableLoadCoeff=1, SELCoeff=idx; unconditionally -> MAC next cycle.
REQ-019 MAC: SELCoeff=idx, InReady=1, InDato=InSample, Acumulador=acc; EnableMul=EnableSum=InValid.
REQ-020 MAC with InValid=1: acc<=OutDato, ErrorFlag<=ErrorFlag|Error; if idx==NumInputs-1 -> LOADOFF else idx<=idx+1 -> LOAD.
REQ-021 MAC with InValid=0: hold state, idx, acc; no enables asserted.
REQ-022 LOADOFF: EnableLoadCoeff=1, SELCoeff=NumInputs -> MACOFF.
REQ-023 MACOFF: InDato = fixed-point 1.0 (1<<Precision), Acumulador=acc, EnableMul=EnableSum=1; acc<=OutDato, ErrorFlag updated as REQ-020 -> DONE; no InReady.
REQ-024 DONE: ResultValid=1, Result stable; ResultReady=1 -> IDLE; otherwise hold indefinitely.
REQ-025 Outside LOAD/MAC/LOADOFF/MACOFF: SELCoeff=0, all enables 0, InDato=0, InReady=0; Acumulador=acc always.
REQ-026 Latency with InValid held 1: ResultValid first asserted 2*NumInputs+3 cycles after the Start-sampling edge (43 for defaults); each InValid=0 cycle in MAC adds one.
REQ-027 Result SHALL be registered from acc (plus REQ-031 if enabled) and remain valid only in DONE; 0 elsewhere.
REQ-028 Arithmetic is done entirely by the attached datapath; block SHALL not widen, round or saturate acc.

Reset
REQ-029 reset=1 SHALL asynchronously force IDLE, idx=0, acc=0, Result=0, ResultValid=0, ErrorFlag=0, Busy=0, all enables 0, InReady=0, SELCoeff=0, InDato=0, Acumulador=0, including mid-evaluation; no pending sample consumed.

Configuration
REQ-030 Macro NEURON_SEQ_RELU_EN SHALL select the output activation.
REQ-031 Defined: Result = 0 when acc sign bit is 1, else acc. Undefined: Result = acc (identity); all timing identical.

Verification
REQ-032 Defaults, all InSample=0, Offset=4'b0010, InValid=1 -> Result=4'b0010, ResultValid at cycle 43, ErrorFlag=0.
REQ-033 Coeff00=4'b0010, InSample[0]=4'b0011, others 0, Offset=0 -> Result=4'b0011; InValid low 5 cycles at idx 3 -> ResultValid at cycle 48, InReady high throughout stall.
REQ-034 Offset=4'b1110 (-1.0), inputs 0 -> Result=4'b1110 without NEURON_SEQ_RELU_EN, 4'b0000 with it.
REQ-035 Coeff00=Coeff01=4'b0111, InSample=4'b0111 -> datapath Error=1 at idx 0; ErrorFlag=1 held through DONE, cleared by next Start.
REQ-036 reset pulsed at idx 10 -> all outputs 0 same cycle; Start while Busy ignored; ResultReady held low 10 cycles keeps DONE, Result stable.

Source files
------------

// File: rtl/neuron_mac_sequencer.sv
// Control sequencer for one fixed-point neuron: streams NumInputs samples, then the offset.
// Define NEURON_SEQ_RELU_EN to apply a ReLU to the registered result.
module neuron_mac_sequencer #(
    parameter int Width     = 4,
    parameter int Magnitud  = 2,
    parameter int Precision = 1,
    parameter int Signo     = 1,
    parameter int NumInputs = 20
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    Start,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic signed [Width-1:0] InSample,
    output logic [4:0]              SELCoeff,
    output logic                    EnableLoadCoeff,
    output logic                    EnableMul,
    output logic                    EnableSum,
    output logic signed [Width-1:0] InDato,
    output logic signed [Width-1:0] Acumulador,
    input  logic signed [Width-1:0] OutDato,
    input  logic                    Error,
    output logic signed [Width-1:0] Result,
    output logic                    ResultValid,
    input  logic                    ResultReady,
    output logic                    Busy,
    output logic                    ErrorFlag
);

    // The word must split exactly into sign, integer and fraction fields, and the
    // offset select (NumInputs) must fit the 5-bit coefficient select.
    if (Signo + Magnitud + Precision != Width || NumInputs < 1 || NumInputs > 20) begin : g_bad_cfg
        $error("neuron_mac_sequencer: inconsistent fixed-point format or NumInputs");
    end

    localparam logic [4:0]              LastIdx   = 5'(NumInputs - 1);
    localparam logic [4:0]              OffsetSel = 5'(NumInputs);
    localparam logic signed [Width-1:0] FixedOne  = Width'(1 << Precision);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_LOADOFF,
        S_MACOFF,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [4:0]                idx;
    logic signed [Width-1:0]   acc;

    function automatic logic signed [Width-1:0] activate(input logic signed [Width-1:0] value);
`ifdef NEURON_SEQ_RELU_EN
        activate = value[Width-1] ? '0 : value;
`else
        activate = value;
`endif
    endfunction

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        InReady         = 1'b0;
        SELCoeff        = '0;
        EnableLoadCoeff = 1'b0;
        EnableMul       = 1'b0;
        EnableSum       = 1'b0;
        InDato          = '0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                EnableLoadCoeff = 1'b1;
                SELCoeff        = idx;
                next_state      = S_MAC;
            end
            S_MAC: begin
                SELCoeff  = idx;
                InReady   = 1'b1;
                InDato    = InSample;
                EnableMul = InValid;
                EnableSum = InValid;
                if (InValid) begin
                    next_state = (idx == LastIdx) ? S_LOADOFF : S_LOAD;
                end
            end
            S_LOADOFF: begin
                EnableLoadCoeff = 1'b1;
                SELCoeff        = OffsetSel;
                next_state      = S_MACOFF;
            end
            S_MACOFF: begin
                // The offset term is offset * 1.0, reusing the same multiply-add path.
                SELCoeff   = OffsetSel;
                InDato     = FixedOne;
                EnableMul  = 1'b1;
                EnableSum  = 1'b1;
                next_state = S_DONE;
            end
            S_DONE: begin
                if (ResultValid && ResultReady) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            acc         <= '0;
            ErrorFlag   <= 1'b0;
            Result      <= '0;
            ResultValid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        idx       <= '0;
                        acc       <= '0;
                        ErrorFlag <= 1'b0;
                    end
                end
                S_MAC: begin
                    if (InValid) begin
                        acc       <= OutDato;
                        ErrorFlag <= ErrorFlag | Error;
                        if (idx != LastIdx) begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                S_MACOFF: begin
                    acc       <= OutDato;
                    ErrorFlag <= ErrorFlag | Error;
                end
                S_DONE: begin
                    // Result is captured on the first DONE cycle and cleared on handoff,
                    // so it reads zero in every other state.
                    if (ResultValid && ResultReady) begin
                        ResultValid <= 1'b0;
                        Result      <= '0;
                    end else begin
                        ResultValid <= 1'b1;
                        Result      <= activate(acc);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Acumulador = acc;
    assign Busy       = (state != S_IDLE);

endmodule
